// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser followed by a mid-bit sampling FSM.
// Bit timing shares CLKS_PER_BIT with the transmitter so one value sets both directions.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    CLEANUP   = 3'd5
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic       meta_q;
  logic       rx_s_q;
  logic       dv_q;
  logic [7:0] byte_q;
  logic       act_q;
  logic       ferr_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      meta_q <= 1'b0;
      rx_s_q <= 1'b0;
    end else begin
      meta_q <= i_RX_Serial;
      rx_s_q <= meta_q;
    end
  end

  // DV and Frame_Err default low every cycle so each can only pulse for one cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= WAIT_HIGH;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      dv_q    <= 1'b0;
      byte_q  <= 8'd0;
      act_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        WAIT_HIGH: begin
          cnt_q <= 8'd0;
          act_q <= 1'b0;
          if (rx_s_q) state_q <= IDLE;
        end
        IDLE: begin
          cnt_q <= 8'd0;
          idx_q <= 3'd0;
          if (!rx_s_q) begin
            state_q <= START;
            act_q   <= 1'b1;
          end
        end
        START: begin
          if (cnt_q < HALF) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= 8'd0;
            if (!rx_s_q) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              act_q   <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt_q < LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q          <= 8'd0;
            shift_q[idx_q] <= rx_s_q;
            if (idx_q == 3'd7) begin
              idx_q   <= 3'd0;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (cnt_q < LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= 8'd0;
            act_q <= 1'b0;
            if (rx_s_q) begin
              byte_q  <= shift_q;
              dv_q    <= 1'b1;
              state_q <= CLEANUP;
            end else begin
              // A low stop bit may be a break; re-arm only once the line goes idle.
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end
        end
        CLEANUP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= WAIT_HIGH;
          cnt_q   <= 8'd0;
          idx_q   <= 3'd0;
          act_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Active    = act_q;
  assign o_RX_Frame_Err = ferr_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial 8N1 UART receiver, the receive-side companion to the team's existing UART transmitter. Samples an asynchronous serial line, recovers one byte per frame, and presents it with a single-cycle valid strobe to the consuming logic (8080 I/O port / console path). Bit timing uses the same `CLKS_PER_BIT` convention and default as the transmitter, so one parameter value sets both directions to the same baud rate.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per serial bit; legal range 4..256 (8-bit counter)
- `i_Clock`  in  1  system clock, all logic on rising edge
- `i_Reset`  in  1  synchronous, active-high reset
- `i_RX_Serial`  in  1  asynchronous serial line, idle high
- `o_RX_DV`  out  1  one-cycle pulse: `o_RX_Byte` holds a newly received, correctly framed byte
- `o_RX_Byte`  out  8  last good byte; updated only on good frames, held otherwise
- `o_RX_Active`  out  1  high from start-bit detection until stop-bit sample
- `o_RX_Frame_Err`  out  1  one-cycle pulse: stop bit sampled low

## Operation
- Input synchroniser: two flops, `i_RX_Serial` -> meta -> `rx_s`; both reset to 0. FSM uses `rx_s` only.
- Half-bit constant `HALF = (CLKS_PER_BIT-1)/2`, integer division (108 at default).
- States:
  - WAIT_HIGH (reset state): counter 0, Active 0; `rx_s`=1 -> IDLE. Prevents a frame starting mid-byte after reset or break.
  - IDLE: counter 0, bit index 0; `rx_s`=0 -> START, Active<=1.
  - START: counter increments while < HALF; at HALF: `rx_s`=0 -> DATA, counter 0; `rx_s`=1 -> glitch, IDLE, Active<=0.
  - DATA: counter increments while < CLKS_PER_BIT-1; at CLKS_PER_BIT-1: shift reg[bit index]<=`rx_s`, counter 0; index 7 -> STOP, index 0; else index+1. LSB first.
  - STOP: counter increments while < CLKS_PER_BIT-1; at CLKS_PER_BIT-1: Active<=0, counter 0; `rx_s`=1 -> `o_RX_Byte`<=shift reg, DV<=1, CLEANUP; `rx_s`=0 -> Frame_Err<=1, WAIT_HIGH (byte not updated).
  - CLEANUP: one cycle, DV<=0, -> IDLE.
  - Unused encodings -> WAIT_HIGH.
- DV and Frame_Err never both high; each high exactly one cycle per frame.
- Break (line held low) produces one Frame_Err, then nothing until line returns high.

## Timing
- Reset values: `o_RX_DV`=0, `o_RX_Byte`=8'h00, `o_RX_Active`=0, `o_RX_Frame_Err`=0, state WAIT_HIGH, counter 0, index 0, shift reg 0.
- Reset takes effect on any clock edge with `i_Reset`=1, including mid-frame; partial byte discarded, no DV/Err.
- Leaving reset with line high: IDLE reached on 3rd edge (two sync stages + WAIT_HIGH).
- Latency: taking edge E0 as first edge with `i_RX_Serial` low (line idle in IDLE), `rx_s` low after E1, START entered at E2, DATA at E2+HALF+1, bit n sampled at E2+HALF+1+(n+1)·CLKS_PER_BIT, DV/Err registered at E(3+HALF+9·CLKS_PER_BIT) = E2064 at default.
- `o_RX_Active` rises at E2, falls at same edge DV/Err rise.
- Minimum accepted inter-frame gap: CLEANUP + IDLE = 2 cycles after stop sample; back-to-back frames at full baud received without loss.
- Low pulse on line shorter than HALF+1 cycles (after sync): rejected, no outputs except Active pulse.

## Test plan
- Reset, line idle high, send 0xA5 at 217 clk/bit -> exactly one DV pulse at E2064, `o_RX_Byte`=0xA5, Frame_Err never high, Active high E2..E2064.
- Back-to-back 0x00 then 0xFF then 0x55 with 1-bit gaps and zero extra gap -> three DV pulses, bytes 0x00, 0xFF, 0x55 in order.
- 50-cycle low glitch on idle line -> no DV, no Err, Active returns 0; following 0x3C frame received correctly.
- Frame 0x81 with stop bit driven low, line held low 2000 cycles, then high, then frame 0x3C -> one Frame_Err pulse, `o_RX_Byte` stays at prior value during error, no second Err during hold, then DV with 0x3C.
- Assert `i_Reset` one cycle during bit 4 of 0x96, release with line still mid-frame -> no DV/Err for that frame, outputs at reset values, next full frame 0x69 received correctly.
- Parameter `CLKS_PER_BIT`=16, send 0xC3 -> DV at edge 3+7+144=154, byte 0xC3.
